// File: rtl/onehot_demux_buf.sv
// rtl/onehot_demux_buf.sv - registered 1-to-N valid/ready demux steered by a one-hot selector
// Optional macro ONEHOT_DEMUX_CHECK_EN: discard non-one-hot beats and pulse err.
module onehot_demux_buf #(
    parameter int N_OUTPUTS = 2,
    parameter int W_DATA    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_DATA-1:0]    in_data,
    input  logic [N_OUTPUTS-1:0] in_sel,
    output logic [N_OUTPUTS-1:0] out_valid,
    input  logic [N_OUTPUTS-1:0] out_ready,
    output logic [W_DATA-1:0]    out_data,
    output logic                 err
);
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic                 r_main_valid;
    logic                 r_skid_valid;
    logic                 r_in_ready;
    logic [W_DATA-1:0]    r_main_data;
    logic [W_DATA-1:0]    r_skid_data;
    logic [N_OUTPUTS-1:0] r_main_sel;
    logic [N_OUTPUTS-1:0] r_skid_sel;

    logic                 w_acc;
    logic                 w_hand;
    logic                 w_load;
    logic [1:0]           w_state;

    assign w_acc   = in_valid & r_in_ready;
    assign w_hand  = |(out_valid & out_ready);
    assign w_state = {r_skid_valid, r_main_valid};

`ifdef ONEHOT_DEMUX_CHECK_EN
    logic w_sel_ok;
    logic r_err;

    // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
    assign w_sel_ok = (in_sel != '0) && ((in_sel & (in_sel - N_OUTPUTS'(1))) == '0);
    assign w_load   = w_acc & w_sel_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_acc & ~w_sel_ok;
        end
    end

    assign err = r_err;
`else
    assign w_load = w_acc;
    assign err    = 1'b0;
`endif

    assign out_valid = {N_OUTPUTS{r_main_valid}} & r_main_sel;
    assign out_data  = r_main_data;
    assign in_ready  = r_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_main_sel   <= '0;
            r_skid_sel   <= '0;
        end else begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_load) begin
                        r_main_valid <= 1'b1;
                        r_main_data  <= in_data;
                        r_main_sel   <= in_sel;
                    end
                end
                ST_ONE: begin
                    if (w_hand) begin
                        if (w_load) begin
                            r_main_data <= in_data;
                            r_main_sel  <= in_sel;
                        end else begin
                            r_main_valid <= 1'b0;
                        end
                    end else if (w_load) begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= in_data;
                        r_skid_sel   <= in_sel;
                        r_in_ready   <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_hand) begin
                        r_main_data  <= r_skid_data;
                        r_main_sel   <= r_skid_sel;
                        r_skid_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end
                end
                default: begin
                    // Skid without main is unreachable; drop it and reopen upstream.
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/onehot_demux_buf.md
# onehot_demux_buf

Registered 1-to-N stream demultiplexer steered by a one-hot destination bitmap. It is the fan-out counterpart of the one-hot and-or mux used on our fan-in paths. A single upstream valid/ready stream carries a data word and a one-hot destination selector; the block buffers the beat and presents it to exactly one of N downstream valid/ready channels. A two-entry skid structure gives full throughput with registered `in_ready`, and the block sits between a bus master port and per-slave response/request channels.

## Interface
- `N_OUTPUTS`, default 2: number of downstream channels, minimum 2.
- `W_DATA`, default 32: data word width.

- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  upstream may transfer; registered
- `in_data`  in  W_DATA  upstream data
- `in_sel`  in  N_OUTPUTS  one-hot destination bitmap
- `out_valid`  out  N_OUTPUTS  per-channel valid; at most one bit set
- `out_ready`  in  N_OUTPUTS  per-channel ready
- `out_data`  out  W_DATA  data word, broadcast to all channels
- `err`  out  1  malformed-selector pulse; only functional with `ONEHOT_DEMUX_CHECK_EN`

## Operation
- Storage:
  - Main entry: `main_valid`, `main_data`, `main_sel`.
  - Skid entry: `skid_valid`, `skid_data`, `skid_sel`.
- Upstream transfer (`acc`): `in_valid & in_ready`.
- Downstream transfer (`hand`): `|(out_valid & out_ready)`.
- Combinational outputs:
  - `out_valid = {N_OUTPUTS{main_valid}} & main_sel`.
  - `out_data = main_data`.
- `in_ready = !skid_valid`, a pure register output.
- States, encoded by {`skid_valid`, `main_valid`}:
  - EMPTY:
    - `acc` loads main and moves to ONE.
    - `out_valid` is 0, so no handoff is possible.
  - ONE:
    - `acc & hand` reloads main with the new beat and stays in ONE.
    - `hand` only clears main and moves to EMPTY.
    - `acc` only loads skid and moves to TWO.
  - TWO:
    - `in_ready` is 0, so no `acc` can occur.
    - `hand` copies skid into main, clears skid, and moves to ONE.
- A beat is held on its channel until accepted. Data and sel in main must not change while `main_valid` is set without a `hand`.
- Without the macro, `in_sel` must be exactly one-hot on every accepted beat. A zero selector deadlocks the buffer, and a multi-hot selector asserts several `out_valid` bits; both are protocol violations.
- Reset:
  - `main_valid`, `skid_valid` and all data/sel registers clear to 0.
  - `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `err` = 0.
  - Reset mid-transfer discards both entries immediately; no beat is delivered after reset deasserts.

## Timing
- Latency: a beat accepted in cycle t is visible on `out_valid` in cycle t+1.
- Throughput: one beat per cycle sustained while the destination is ready, including when consecutive beats target different channels.
- Backpressure: if the destination stalls, `in_ready` falls in the cycle after the second beat is accepted. It rises in the cycle after the `hand` that empties skid.
- There is no combinational path from `out_ready` to `in_ready`. `in_*` to `out_*` paths are fully registered.

## Configuration
- `ONEHOT_DEMUX_CHECK_EN` defined:
  - An accepted beat whose `in_sel` is zero or has more than one bit set is consumed and discarded; buffer state is unchanged.
  - `err` is a registered output, asserted high for exactly one cycle, the cycle after the discarded transfer.
  - `in_ready` behaviour is unchanged.
- Macro undefined:
  - `err` is tied to 0.
  - No selector checking logic is present; non-one-hot selectors are a protocol violation as described above.

## Test plan
- Reset then single beat: `in_data`=0xDEADBEEF, `in_sel`=4'b0100 (N_OUTPUTS=4), all `out_ready`=1. Required next cycle: `out_valid`=4'b0100 and `out_data`=0xDEADBEEF. Required the following cycle: `out_valid`=0.
- Streaming: 8 back-to-back beats, data 1..8, `in_sel` cycling 0001, 0010, 0100, 1000, with all ready. Required: `in_ready` stays 1 throughout, and each beat appears exactly once, in order, on the correct channel, one cycle after acceptance.
- Backpressure: `out_ready[1]`=0 and beats A, B sent to channel 1 on consecutive cycles. Required: `in_ready`=0 from the cycle after B is accepted. Raising `out_ready[1]` then delivers A, then B, and `in_ready` returns to 1 one cycle after B's slot frees.
- Cross-channel head-of-line: beat to channel 0 with `out_ready[0]`=0, then a beat to channel 2 with `out_ready[2]`=1. Required: the channel-2 beat is not delivered before the channel-0 beat, so order is preserved.
- Reset mid-operation: TWO state is held under backpressure and `rst` is pulsed for 1 cycle. Required: `out_valid`=0 and `in_ready`=1 immediately, and no stale beat appears afterwards.
- With `ONEHOT_DEMUX_CHECK_EN`: send `in_sel`=4'b0000, then 4'b0110, then 4'b0001 with data 0x55. Required: `err` pulses once for each of the first two beats, and only 0x55 appears, on channel 0.
